mpp_program_mem: RTL and testbench

- Program memory responder for the mpp core; it is the memory end of the core's instruction-fetch interface.
- The core presents program_addr and raises out_signals[1] (program read strobe). This block returns the byte on instruction and flags it with instr_ready after a configurable wait-state count.
- A byte-serial loader port fills the memory from address 0 before or between runs.
- Replaces the behavioural case-table program store used on the bench.

---
 rtl/mpp_program_mem.sv | 214 +++++++++++++++++++++
 tb/tb_mpp_program_mem.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpp_program_mem.sv
// mpp_program_mem: program memory responder for the mpp core fetch port.
// Serves strobe-edge fetches after WAIT_STATES extra cycles.
// Filled from address 0 by a byte-serial loader.
// Optional build macro MPP_PROG_PARITY_EN adds per-byte even parity and a parity_err output.
module mpp_program_mem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] program_addr,
  input  logic [4:0]  out_signals,
  output logic [7:0]  instruction,
  output logic        instr_ready,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  output logic        load_done
`ifdef MPP_PROG_PARITY_EN
  ,
  output logic        parity_err
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    F_IDLE,
    F_WAIT,
    F_RESP
  } fetch_state_t;

  typedef enum logic {
    L_IDLE,
    L_ACTIVE
  } load_state_t;

  logic [7:0] mem [DEPTH];
`ifdef MPP_PROG_PARITY_EN
  logic       mem_par [DEPTH];
  logic       parity_err_n;
`endif

  fetch_state_t           fstate, fstate_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [15:0]            addr_q, addr_n;
  logic                   pend, pend_n;
  logic [15:0]            pend_addr, pend_addr_n;
  logic                   strobe_q;
  logic [7:0]             instruction_n;
  logic                   instr_ready_n;
  logic                   req_taken;

  load_state_t            lstate, lstate_n;
  logic [ADDR_WIDTH-1:0]  ptr, ptr_n;
  logic                   load_ready_n;
  logic                   load_done_n;
  logic                   mem_we;

  logic                   fetch_req;
  logic                   blocked;
  logic                   rd_in_range;
  logic [7:0]             rd_byte;
  logic                   unused_ctrl_bits;

  // Only the program read strobe of the control bus matters here
  assign unused_ctrl_bits = ^{out_signals[4:2], out_signals[0]};

  // Fetch request is the rising edge of the read strobe; reads are held off while loading
  assign fetch_req   = out_signals[1] & ~strobe_q;
  assign blocked     = (lstate == L_ACTIVE) | load_start;
  assign rd_in_range = (addr_q >> ADDR_WIDTH) == 16'd0;
  assign rd_byte     = rd_in_range ? mem[addr_q[ADDR_WIDTH-1:0]] : FILL_BYTE;

  // Fetch FSM next-state and next registered outputs
  always_comb begin
    fstate_n      = fstate;
    cnt_n         = cnt;
    addr_n        = addr_q;
    pend_n        = pend;
    pend_addr_n   = pend_addr;
    instruction_n = instruction;
    instr_ready_n = 1'b0;
    req_taken     = 1'b0;
`ifdef MPP_PROG_PARITY_EN
    parity_err_n  = parity_err;
`endif
    case (fstate)
      F_IDLE: begin
        if (pend && !blocked) begin
          addr_n   = pend_addr;
          pend_n   = 1'b0;
          cnt_n    = '0;
          fstate_n = F_WAIT;
        end else if (fetch_req && !blocked) begin
          addr_n    = program_addr;
          cnt_n     = '0;
          fstate_n  = F_WAIT;
          req_taken = 1'b1;
        end
      end
      F_WAIT: begin
        if (cnt == CNT_W'(WAIT_STATES)) begin
          cnt_n         = '0;
          fstate_n      = F_RESP;
          instr_ready_n = 1'b1;
          instruction_n = rd_byte;
`ifdef MPP_PROG_PARITY_EN
          parity_err_n  = rd_in_range &
                          ((^mem[addr_q[ADDR_WIDTH-1:0]]) ^ mem_par[addr_q[ADDR_WIDTH-1:0]]);
`endif
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      F_RESP: begin
        if (pend && !blocked) begin
          addr_n   = pend_addr;
          pend_n   = 1'b0;
          cnt_n    = '0;
          fstate_n = F_WAIT;
        end else begin
          fstate_n = F_IDLE;
        end
      end
      default: fstate_n = F_IDLE;
    endcase
    // An edge not started directly becomes the single pending request, if the slot is free
    if (fetch_req && !req_taken && !pend_n) begin
      pend_n      = 1'b1;
      pend_addr_n = program_addr;
    end
  end

  // Fetch FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fstate      <= F_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      pend        <= 1'b0;
      pend_addr   <= '0;
      strobe_q    <= 1'b0;
      instruction <= 8'h00;
      instr_ready <= 1'b0;
`ifdef MPP_PROG_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      fstate      <= fstate_n;
      cnt         <= cnt_n;
      addr_q      <= addr_n;
      pend        <= pend_n;
      pend_addr   <= pend_addr_n;
      strobe_q    <= out_signals[1];
      instruction <= instruction_n;
      instr_ready <= instr_ready_n;
`ifdef MPP_PROG_PARITY_EN
      parity_err  <= parity_err_n;
`endif
    end
  end

  // Loader FSM next-state, pointer and write enable
  always_comb begin
    lstate_n    = lstate;
    ptr_n       = ptr;
    load_done_n = load_done;
    mem_we      = 1'b0;
    if (load_start) begin
      ptr_n       = '0;
      load_done_n = 1'b0;
      lstate_n    = L_ACTIVE;
    end else if (lstate == L_ACTIVE && load_valid && load_ready) begin
      mem_we = 1'b1;
      if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
        lstate_n    = L_IDLE;
        load_done_n = 1'b1;
      end else begin
        ptr_n = ptr + ADDR_WIDTH'(1);
      end
    end
    load_ready_n = (lstate_n == L_ACTIVE);
  end

  // Loader FSM state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      lstate     <= L_IDLE;
      ptr        <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      lstate     <= lstate_n;
      ptr        <= ptr_n;
      load_ready <= load_ready_n;
      load_done  <= load_done_n;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[ptr] <= load_data;
`ifdef MPP_PROG_PARITY_EN
      mem_par[ptr] <= ^load_data;
`endif
    end
  end

endmodule

// File: tb/tb_mpp_program_mem.sv
// Directed self-checking bench for mpp_program_mem (ADDR_WIDTH=8, WAIT_STATES=1).
module tb_mpp_program_mem;

  localparam logic [4:0] SIG_IDLE = 5'b10101;
  localparam logic [4:0] SIG_STB  = 5'b10111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] program_addr;
  logic [4:0]  out_signals;
  logic [7:0]  instruction;
  logic        instr_ready;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        load_done;
`ifdef MPP_PROG_PARITY_EN
  logic        parity_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] prog [17] = '{8'h07, 8'hC0, 8'h55, 8'h07, 8'hC1, 8'h66, 8'h07, 8'h06,
                            8'h00, 8'h0E, 8'h07, 8'h03, 8'h00, 8'h00, 8'h01, 8'h07, 8'h07};

  mpp_program_mem #(
    .ADDR_WIDTH (8),
    .WAIT_STATES(1),
    .FILL_BYTE  (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .program_addr(program_addr),
    .out_signals (out_signals),
    .instruction (instruction),
    .instr_ready (instr_ready),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done)
`ifdef MPP_PROG_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for instr_ready and returns the cycle count since the call
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!instr_ready && n < 12);
  endtask

  // One isolated fetch: checks latency, data, and that the pulse lasts one cycle
  task automatic fetch(input logic [15:0] a, input logic [7:0] exp, input string tag);
    int n;
    out_signals  = SIG_STB;
    program_addr = a;
    tick();
    program_addr = ~a;
    n = 1;
    while (!instr_ready && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd3);
    chk({tag, "_data"}, 32'(instruction), 32'(exp));
    out_signals = SIG_IDLE;
    tick();
    chk({tag, "_pulse_end"}, 32'(instr_ready), 32'd0);
  endtask

  initial begin
    int  n;
    logic seen;

    rst          = 1'b1;
    program_addr = 16'h0000;
    out_signals  = SIG_IDLE;
    load_start   = 1'b0;
    load_valid   = 1'b0;
    load_data    = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_instruction", 32'(instruction), 32'h00);
    chk("rst_instr_ready", 32'(instr_ready), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
`ifdef MPP_PROG_PARITY_EN
    chk("rst_parity_err", 32'(parity_err), 32'd0);
`endif

    // Load the 17-byte program
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_ready_after_start", 32'(load_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 17; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      tick();
      if (!load_ready || load_done) seen = 1'b1;
    end
    load_valid = 1'b0;
    chk("load17_ready_held_done_low", 32'(seen), 32'd0);
    chk("load17_done", 32'(load_done), 32'd0);

    // Fetch while loading stays pending until the loader finishes
    out_signals  = SIG_STB;
    program_addr = 16'h0005;
    tick();
    out_signals  = SIG_IDLE;
    program_addr = 16'h0002;
    seen = 1'b0;
    for (int i = 17; i < 256; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i);
      tick();
      if (instr_ready) seen = 1'b1;
    end
    load_valid = 1'b0;
    chk("no_ready_during_load", 32'(seen), 32'd0);
    chk("load_done_full", 32'(load_done), 32'd1);
    chk("load_ready_full", 32'(load_ready), 32'd0);
    wait_ready(n);
    chk("pending_latency", 32'(n), 32'd3);
    chk("pending_data", 32'(instruction), 32'h66);
    tick();
    chk("pending_pulse_end", 32'(instr_ready), 32'd0);

    // Plain fetches and out of range
    fetch(16'h0002, 8'h55, "fetch_02");
    fetch(16'h000F, 8'h07, "fetch_0F");
    fetch(16'h0100, 8'h00, "fetch_oor");

    // load_valid while the loader is idle must not write
    load_valid = 1'b1;
    load_data  = 8'h5A;
    tick();
    load_valid = 1'b0;
    fetch(16'h00FF, 8'hFF, "fetch_FF_no_stray_write");

    // Back-to-back: edges two cycles apart, then strobe held high
    out_signals  = SIG_STB;
    program_addr = 16'h0000;
    tick();
    out_signals  = SIG_IDLE;
    program_addr = 16'hFFFF;
    tick();
    out_signals  = SIG_STB;
    program_addr = 16'h0001;
    tick();
    program_addr = 16'h0002;
    chk("b2b_first_ready", 32'(instr_ready), 32'd1);
    chk("b2b_first_data", 32'(instruction), 32'h07);
    wait_ready(n);
    chk("b2b_second_latency", 32'(n), 32'd3);
    chk("b2b_second_data", 32'(instruction), 32'hC0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (instr_ready) seen = 1'b1;
    end
    chk("held_strobe_no_extra", 32'(seen), 32'd0);
    out_signals = SIG_IDLE;
    tick();

    // Reset while in WAIT drops the fetch
    out_signals  = SIG_STB;
    program_addr = 16'h0003;
    tick();
    out_signals = SIG_IDLE;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wait_instruction", 32'(instruction), 32'h00);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (instr_ready) seen = 1'b1;
      tick();
    end
    chk("rst_wait_no_ready", 32'(seen), 32'd0);
    chk("rst_wait_load_done", 32'(load_done), 32'd0);
    fetch(16'h0004, 8'hC1, "fetch_after_rst");

`ifdef MPP_PROG_PARITY_EN
    dut.mem[1] = dut.mem[1] ^ 8'h01;
    fetch(16'h0001, 8'hC1, "parity_flip_fetch");
    chk("parity_err_flipped", 32'(parity_err), 32'd1);
    fetch(16'h0002, 8'h55, "parity_clean_fetch");
    chk("parity_err_clean", 32'(parity_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
